// File: rtl/key_event_gen.sv
// ============================================================================
//  Module      : key_event_gen
//  Description : Turns the raw two-byte HID keycode word into single-cycle game
//                commands with delayed auto-shift and auto-repeat.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_gen #(
    parameter int DAS_CYCLES = 10_000_000,
    parameter int ARR_CYCLES = 2_500_000,
    parameter int CNT_W      = 24
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] keycode,
    input  logic        enable,
    input  logic        touchdown,
    output logic [2:0]  keypress,
    output logic        key_pulse,
    output logic        key_held
);

    localparam logic [2:0]       c_CMD_NONE = 3'd0;
    localparam logic [2:0]       c_CMD_DOWN = 3'd3;
    localparam logic [CNT_W-1:0] c_DAS_LAST = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ARR_LAST = CNT_W'(ARR_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DELAY    = 2'd1,
        S_REPEAT   = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_timer, w_timer_nxt, w_timer_inc;
    logic [2:0]       r_cur_cmd, w_cur_cmd_nxt;
    logic [15:0]      r_kc_q;
    logic [2:0]       w_cmd_b0, w_cmd_b1, w_cmd;
    logic             w_repeatable;
    logic             w_new_press;
    logic             w_pulse;
    logic [2:0]       w_code;

    function automatic logic [2:0] decode_byte(input logic [7:0] b);
        case (b)
            8'h50, 8'h04: decode_byte = 3'd1;
            8'h4F, 8'h07: decode_byte = 3'd2;
            8'h51, 8'h16: decode_byte = 3'd3;
            8'h52, 8'h1A: decode_byte = 3'd4;
            8'h2C:        decode_byte = 3'd5;
            8'h06:        decode_byte = 3'd6;
            default:      decode_byte = 3'd0;
        endcase
    endfunction

    // Byte 0 wins; byte 1 is only consulted when byte 0 is not a game key.
    assign w_cmd_b0     = decode_byte(r_kc_q[7:0]);
    assign w_cmd_b1     = decode_byte(r_kc_q[15:8]);
    assign w_cmd        = (w_cmd_b0 != c_CMD_NONE) ? w_cmd_b0 : w_cmd_b1;
    assign w_repeatable = (w_cmd == 3'd1) || (w_cmd == 3'd2) || (w_cmd == 3'd3);
    assign w_timer_inc  = (r_timer == c_CNT_MAX) ? r_timer : r_timer + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_cur_cmd_nxt = r_cur_cmd;
        w_new_press   = 1'b0;
        w_pulse       = 1'b0;
        w_code        = c_CMD_NONE;

        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
        end else if (r_state == S_IDLE) begin
            w_new_press = (w_cmd != c_CMD_NONE);
        end else if (w_cmd == c_CMD_NONE) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
        end else if (w_cmd != r_cur_cmd) begin
            w_new_press = 1'b1;
        end else if (r_state != S_WAIT_REL && touchdown && r_cur_cmd == c_CMD_DOWN) begin
            // Landing cancels a held soft drop so it cannot carry into the next piece.
            w_state_nxt = S_WAIT_REL;
            w_timer_nxt = '0;
        end else if (r_state == S_DELAY) begin
            if (r_timer == c_DAS_LAST) begin
                w_pulse     = 1'b1;
                w_code      = r_cur_cmd;
                w_timer_nxt = '0;
                w_state_nxt = S_REPEAT;
            end else begin
                w_timer_nxt = w_timer_inc;
            end
        end else if (r_state == S_REPEAT) begin
            if (r_timer == c_ARR_LAST) begin
                w_pulse     = 1'b1;
                w_code      = r_cur_cmd;
                w_timer_nxt = '0;
            end else begin
                w_timer_nxt = w_timer_inc;
            end
        end

        if (w_new_press) begin
            w_pulse       = 1'b1;
            w_code        = w_cmd;
            w_cur_cmd_nxt = w_cmd;
            w_timer_nxt   = '0;
            w_state_nxt   = w_repeatable ? S_DELAY : S_WAIT_REL;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_cur_cmd <= c_CMD_NONE;
            r_kc_q    <= '0;
            keypress  <= c_CMD_NONE;
            key_pulse <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_cur_cmd <= w_cur_cmd_nxt;
            r_kc_q    <= keycode;
            keypress  <= w_pulse ? w_code : c_CMD_NONE;
            key_pulse <= w_pulse;
            key_held  <= (w_state_nxt != S_IDLE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_key_event_gen.sv
// ============================================================================
//  Module      : tb_key_event_gen
//  Description : Directed self-checking bench for key_event_gen (DAS=8, ARR=3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_event_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keycode;
    logic        enable;
    logic        touchdown;
    logic [2:0]  keypress;
    logic        key_pulse;
    logic        key_held;

    int n_checks = 0;
    int n_errors = 0;

    key_event_gen #(
        .DAS_CYCLES (8),
        .ARR_CYCLES (3),
        .CNT_W      (24)
    ) u_dut (
        .Clk       (clk),
        .Reset     (rst),
        .keycode   (keycode),
        .enable    (enable),
        .touchdown (touchdown),
        .keypress  (keypress),
        .key_pulse (key_pulse),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] bt(input int i);
        bt = 64'd1 << i;
    endfunction

    function automatic logic [63:0] rng(input int lo, input int hi);
        rng = '0;
        for (int k = lo; k <= hi; k++) rng |= (64'd1 << k);
    endfunction

    // Cycle i views the outputs after the i-th rising edge following the call.
    task automatic run(input string tag, input int ncyc, input int rel_at,
                       input logic [15:0] rel_val, input int td_at,
                       input logic [63:0] pmask, input logic [2:0] code,
                       input logic [63:0] hmask);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            touchdown = 1'b0;
            check($sformatf("%s_pulse_c%0d", tag, i), 32'(key_pulse), 32'(pmask[i]));
            check($sformatf("%s_code_c%0d", tag, i), 32'(keypress),
                  pmask[i] ? 32'(code) : 32'd0);
            check($sformatf("%s_held_c%0d", tag, i), 32'(key_held), 32'(hmask[i]));
            if (i == td_at)  touchdown = 1'b1;
            if (i == rel_at) keycode   = rel_val;
        end
    endtask

    initial begin
        rst       = 1'b1;
        keycode   = 16'h0000;
        enable    = 1'b1;
        touchdown = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_keypress", 32'(keypress), 32'd0);
        check("rst_pulse",    32'(key_pulse), 32'd0);
        check("rst_held",     32'(key_held), 32'd0);
        rst = 1'b0;
        run("idle", 2, 0, 16'h0, 0, '0, 3'd0, '0);

        // LEFT held 20 cycles: first pulse, DAS, then ARR repeats
        keycode = 16'h0050;
        run("left", 26, 20, 16'h0000, 0,
            bt(2) | bt(10) | bt(13) | bt(16) | bt(19), 3'd1, rng(2, 21));

        // ROTATE is one-shot; re-press gives another
        keycode = 16'h0052;
        run("rot1", 22, 20, 16'h0000, 0, bt(2), 3'd4, rng(2, 21));
        keycode = 16'h0052;
        run("rot2", 6, 3, 16'h0000, 0, bt(2), 3'd4, rng(2, 4));

        // DOWN cancelled by touchdown; stays silent until re-pressed
        keycode = 16'h0051;
        run("down_td", 23, 20, 16'h0000, 6, bt(2), 3'd3, rng(2, 21));
        // touchdown on the very edge the DAS pulse is due: pulse suppressed
        keycode = 16'h0051;
        run("down_td2", 15, 12, 16'h0000, 9, bt(2), 3'd3, rng(2, 13));

        // byte priority, command switch restarting DAS, unknown key
        keycode = 16'h4F50;
        run("prio_l", 5, 5, 16'h4F00, 0, bt(2), 3'd1, rng(2, 5));
        run("prio_r", 14, 14, 16'h00AA, 0, bt(2) | bt(10) | bt(13), 3'd2, rng(1, 14));
        run("unk", 5, 5, 16'h0000, 0, '0, 3'd0, bt(1));
        run("unk_idle", 2, 0, 16'h0, 0, '0, 3'd0, '0);

        // disabled: no pulses; enabling with key held gives one HARD_DROP
        enable  = 1'b0;
        keycode = 16'h002C;
        run("dis", 6, 0, 16'h0, 0, '0, 3'd5, '0);
        enable = 1'b1;
        run("en", 10, 8, 16'h0000, 0, bt(1), 3'd5, rng(1, 9));

        // asynchronous reset in the middle of auto-repeat
        keycode = 16'h0050;
        run("pre_rst", 12, 0, 16'h0, 0, bt(2) | bt(10), 3'd1, rng(2, 12));
        #2 rst = 1'b1;
        #1;
        check("async_keypress", 32'(keypress), 32'd0);
        check("async_pulse",    32'(key_pulse), 32'd0);
        check("async_held",     32'(key_held), 32'd0);
        @(negedge clk);
        check("rst_hold_pulse", 32'(key_pulse), 32'd0);
        rst = 1'b0;
        run("post_rst", 4, 0, 16'h0, 0, bt(2), 3'd1, rng(2, 4));
        keycode = 16'h0000;
        run("final", 3, 0, 16'h0, 0, '0, 3'd0, bt(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
